hwpf_stride_engine: RTL and testbench

HWPF_STRIDE_ENGINE -- requirements
Module: hwpf_stride_engine

---
 rtl/hwpf_stride_engine_if.sv | 22 ++
 rtl/hwpf_stride_engine.sv | 192 +++++++++++++++++++
 tb/tb_hwpf_stride_engine.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hwpf_stride_engine_if.sv
// Entry and request channels of the stride prefetch engine.
// The slave modport is the engine side; master is the environment side.
interface hwpf_stride_engine_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  entry_valid_i;
  logic                  entry_ready_o;
  logic [159:0]          entry_i;
  logic                  req_valid_o;
  logic                  req_ready_i;
  logic [ADDR_WIDTH-1:0] req_addr_o;

  modport slave (
    input  entry_valid_i, entry_i, req_ready_i,
    output entry_ready_o, req_valid_o, req_addr_o
  );

  modport master (
    output entry_valid_i, entry_i, req_ready_i,
    input  entry_ready_o, req_valid_o, req_addr_o
  );
endinterface

// File: rtl/hwpf_stride_engine.sv
// Strided hardware prefetch engine: walks blocks of consecutive cache lines
// separated by a stride, throttled by an in-flight limit, with optional
// inter-block gaps, stream cycling/rearming, abort and drain.
// Addresses are tracked in cache-line units; the running block base is
// advanced incrementally by the stride instead of multiplying blk*stride.
module hwpf_stride_engine #(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  hwpf_stride_engine_if.slave       bus,
  input  logic                      ack_i,
  input  logic                      abort_i,
  output logic                      busy_o,
  output logic [15:0]               inflight_o
);
  localparam int LINE_W = ADDR_WIDTH - 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state_r, state_n;

  // latched entry fields
  logic [LINE_W-1:0] base_r;
  logic [31:0]       stride_r;
  logic [15:0]       nblocks_r, nlines_r, ninflight_r, nwait_r;
  logic              cycle_r, rearm_r;

  // walk state
  logic [LINE_W-1:0] base_n, blk_base_r, blk_base_n;
  logic [15:0]       blk_r, blk_n, line_r, line_n, gap_r, gap_n;
  logic [15:0]       inflight_r, inflight_n;

  logic              latch_s, entry_fire_s, req_fire_s, req_valid_s;
  logic              can_issue_s, ack_dec_s;
  logic [LINE_W-1:0] stride_ext_s, next_blk_base_s, addr_line_s;
  logic              unused_s;

  assign unused_s        = ^bus.entry_i[101:99];
  assign stride_ext_s    = {{(LINE_W-32){1'b0}}, stride_r};
  assign next_blk_base_s = blk_base_r + stride_ext_s;
  assign addr_line_s     = blk_base_r + {{(LINE_W-16){1'b0}}, line_r};

  // A saturated counter blocks issue so it can never wrap to zero.
  assign can_issue_s  = (inflight_r != 16'hFFFF) &&
                        ((ninflight_r == 16'd0) || (inflight_r < ninflight_r));
  // abort_i masks the request in the same cycle so a coincident handshake is void.
  assign req_valid_s  = (state_r == ISSUE) && can_issue_s && !abort_i && !rst_i;
  assign req_fire_s   = req_valid_s && bus.req_ready_i;
  assign ack_dec_s    = ack_i && (inflight_r != 16'd0);

  assign bus.req_valid_o   = req_valid_s;
  assign bus.req_addr_o    = {addr_line_s, 6'b000000};
  assign bus.entry_ready_o = (state_r == IDLE) && !rst_i;
  assign entry_fire_s      = bus.entry_valid_i && bus.entry_ready_o;
  assign busy_o            = (state_r != IDLE);
  assign inflight_o        = inflight_r;

  // Next-state and walk-pointer logic for the stream FSM.
  always_comb begin
    state_n    = state_r;
    base_n     = base_r;
    blk_base_n = blk_base_r;
    blk_n      = blk_r;
    line_n     = line_r;
    gap_n      = gap_r;
    latch_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (entry_fire_s && bus.entry_i[96]) begin
          latch_s    = 1'b1;
          base_n     = bus.entry_i[159:102];
          blk_base_n = bus.entry_i[159:102];
          blk_n      = 16'd0;
          line_n     = 16'd0;
          state_n    = ISSUE;
        end else begin
          state_n = IDLE;
        end
      end
      ISSUE: begin
        if (abort_i) begin
          state_n = DRAIN;
        end else if (req_fire_s) begin
          if (line_r != nlines_r) begin
            line_n = line_r + 16'd1;
          end else begin
            // end of block: next block (or restart) with optional gap
            line_n  = 16'd0;
            blk_n   = 16'd0;
            gap_n   = nwait_r;
            state_n = (nwait_r != 16'd0) ? GAP : ISSUE;
            if (blk_r != nblocks_r) begin
              blk_n      = blk_r + 16'd1;
              blk_base_n = next_blk_base_s;
            end else if (cycle_r) begin
              blk_base_n = base_r;
            end else if (rearm_r) begin
              // last block base + stride == base + (nblocks+1)*stride
              base_n     = next_blk_base_s;
              blk_base_n = next_blk_base_s;
            end else begin
              state_n = DRAIN;
            end
          end
        end else begin
          state_n = ISSUE;
        end
      end
      GAP: begin
        if (abort_i) begin
          state_n = DRAIN;
        end else if (gap_r <= 16'd1) begin
          state_n = ISSUE;
        end else begin
          gap_n = gap_r - 16'd1;
        end
      end
      DRAIN: begin
        if (inflight_r == 16'd0) begin
          state_n = IDLE;
        end else begin
          state_n = DRAIN;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // In-flight counter: +1 per request handshake, -1 per ack, net zero for both.
  always_comb begin
    inflight_n = inflight_r;
    if (req_fire_s && !ack_dec_s) begin
      inflight_n = inflight_r + 16'd1;
    end else if (!req_fire_s && ack_dec_s) begin
      inflight_n = inflight_r - 16'd1;
    end else begin
      inflight_n = inflight_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Walk pointers, in-flight count and latched entry fields.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_r      <= '0;
      blk_base_r  <= '0;
      blk_r       <= 16'd0;
      line_r      <= 16'd0;
      gap_r       <= 16'd0;
      inflight_r  <= 16'd0;
      stride_r    <= 32'd0;
      nblocks_r   <= 16'd0;
      nlines_r    <= 16'd0;
      ninflight_r <= 16'd0;
      nwait_r     <= 16'd0;
      cycle_r     <= 1'b0;
      rearm_r     <= 1'b0;
    end else begin
      base_r     <= base_n;
      blk_base_r <= blk_base_n;
      blk_r      <= blk_n;
      line_r     <= line_n;
      gap_r      <= gap_n;
      inflight_r <= inflight_n;
      if (latch_s) begin
        cycle_r     <= bus.entry_i[98];
        rearm_r     <= bus.entry_i[97];
        nblocks_r   <= bus.entry_i[95:80];
        nlines_r    <= bus.entry_i[79:64];
        stride_r    <= bus.entry_i[63:32];
        ninflight_r <= bus.entry_i[31:16];
        nwait_r     <= bus.entry_i[15:0];
      end
    end
  end
endmodule

// File: tb/tb_hwpf_stride_engine.sv
// Self-checking bench for hwpf_stride_engine: directed vector table,
// hand-written corner sequences and randomized streams checked against
// an arithmetic reference model.
module tb_hwpf_stride_engine;
  logic        clk = 1'b0;
  logic        rst;
  logic        ack;
  logic        abort;
  logic        busy;
  logic [15:0] inflight;

  hwpf_stride_engine_if #(.ADDR_WIDTH(64)) ifc ();

  hwpf_stride_engine #(.ADDR_WIDTH(64)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (ifc.slave),
    .ack_i      (ack),
    .abort_i    (abort),
    .busy_o     (busy),
    .inflight_o (inflight)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [57:0]      base;
    logic [31:0]      stride;
    logic [15:0]      nlines;
    logic [15:0]      nblocks;
    logic [3:0][63:0] exp;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] mk(input logic [57:0] base, input logic cyc_f,
                                      input logic rearm_f, input logic en_f,
                                      input logic [15:0] nb, input logic [15:0] nl,
                                      input logic [31:0] st, input logic [15:0] ni,
                                      input logic [15:0] nw);
    return {base, 3'b000, cyc_f, rearm_f, en_f, nb, nl, st, ni, nw};
  endfunction

  // reference address: base + blk*stride + line, modulo 2^58, shifted to bytes
  function automatic logic [63:0] ref_addr(input logic [57:0] base, input logic [31:0] st,
                                           input int b, input int l);
    logic [57:0] ln;
    ln = base + 58'(b) * 58'(st) + 58'(l);
    return {ln, 6'b000000};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_entry(input logic [159:0] e);
    ifc.entry_i       = e;
    ifc.entry_valid_i = 1'b1;
    @(negedge clk);
    chk("entry_ready", ifc.entry_ready_o, 1'b1);
    cyc();
    ifc.entry_valid_i = 1'b0;
  endtask

  task automatic ack_n(input int n);
    ack = 1'b1;
    repeat (n) cyc();
    ack = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    @(negedge clk);
    while (busy && i < 50) begin
      cyc();
      @(negedge clk);
      i++;
    end
    chk(name, busy, 1'b0);
    chk({name, "_inflight"}, inflight, 16'd0);
    cyc();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt, p0, p1, budget, m_inf, ni;
    logic        hs;
    logic [63:0] a0;
    logic [57:0] rbase;
    logic [31:0] rstride;
    int          rnl, rnb, rnw;
    logic [63:0] q [$];

    tbl[0].base = 58'h100; tbl[0].stride = 32'd4; tbl[0].nlines = 16'd1; tbl[0].nblocks = 16'd1;
    tbl[0].exp  = {64'h4140, 64'h4100, 64'h4040, 64'h4000};
    tbl[1].base = 58'h0; tbl[1].stride = 32'h10; tbl[1].nlines = 16'd0; tbl[1].nblocks = 16'd3;
    tbl[1].exp  = {64'hC00, 64'h800, 64'h400, 64'h0};
    tbl[2].base = 58'h3FFFFFFFFFFFFFF; tbl[2].stride = 32'd1; tbl[2].nlines = 16'd3; tbl[2].nblocks = 16'd0;
    tbl[2].exp  = {64'h80, 64'h40, 64'h0, 64'hFFFFFFFFFFFFFFC0};
    tbl[3].base = 58'h5; tbl[3].stride = 32'hFFFFFFFF; tbl[3].nlines = 16'd1; tbl[3].nblocks = 16'd1;
    tbl[3].exp  = {64'h4000000140, 64'h4000000100, 64'h180, 64'h140};

    rst = 1'b1; ack = 1'b0; abort = 1'b0;
    ifc.entry_valid_i = 1'b0; ifc.entry_i = '0; ifc.req_ready_i = 1'b1;
    repeat (3) cyc();

    // reset state
    @(negedge clk);
    chk("rst_entry_ready", ifc.entry_ready_o, 1'b0);
    chk("rst_req_valid", ifc.req_valid_o, 1'b0);
    chk("rst_req_addr", ifc.req_addr_o, 64'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_inflight", inflight, 16'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", ifc.entry_ready_o, 1'b1);
    cyc();

    // directed vector table: 4 back-to-back requests, then drain
    for (int v = 0; v < 4; v++) begin
      send_entry(mk(tbl[v].base, 1'b0, 1'b0, 1'b1, tbl[v].nblocks, tbl[v].nlines,
                    tbl[v].stride, 16'd0, 16'd0));
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("tbl_valid", ifc.req_valid_o, 1'b1);
        chk("tbl_addr", ifc.req_addr_o, tbl[v].exp[k]);
        cyc();
      end
      @(negedge clk);
      chk("tbl_valid_end", ifc.req_valid_o, 1'b0);
      chk("tbl_drain_busy", busy, 1'b1);
      chk("tbl_inflight", inflight, 16'd4);
      cyc();
      ack_n(4);
      wait_idle("tbl_idle");
    end

    // throttle: limit 2, then one ack releases exactly one request
    send_entry(mk(58'h200, 1'b0, 1'b0, 1'b1, 16'd0, 16'd7, 32'd1, 16'd2, 16'd0));
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ifc.req_valid_o && ifc.req_ready_i) cnt++;
      cyc();
    end
    chk("thr_first_count", cnt, 2);
    @(negedge clk);
    chk("thr_blocked", ifc.req_valid_o, 1'b0);
    cyc();
    ack_n(1);
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ifc.req_valid_o && ifc.req_ready_i) cnt++;
      cyc();
    end
    chk("thr_after_ack", cnt, 1);
    chk("thr_inflight", inflight, 16'd2);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    ack_n(2);
    wait_idle("thr_idle");

    // gap: nwait=3 gives three idle cycles between the two blocks
    send_entry(mk(58'h40, 1'b0, 1'b0, 1'b1, 16'd1, 16'd0, 32'd8, 16'd0, 16'd3));
    cnt = 0; p0 = -1; p1 = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (ifc.req_valid_o) begin
        if (cnt == 0) p0 = c; else p1 = c;
        chk("gap_addr", ifc.req_addr_o, ref_addr(58'h40, 32'd8, cnt, 0));
        cnt++;
      end
      cyc();
    end
    chk("gap_count", cnt, 2);
    chk("gap_first_pos", p0, 0);
    chk("gap_second_pos", p1, 4);
    ack_n(2);
    wait_idle("gap_idle");

    // backpressure then abort
    ifc.req_ready_i = 1'b0;
    send_entry(mk(58'h20, 1'b0, 1'b0, 1'b1, 16'd0, 16'd3, 32'd1, 16'd0, 16'd0));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", ifc.req_valid_o, 1'b1);
      chk("bp_addr", ifc.req_addr_o, 64'h800);
      cyc();
    end
    abort = 1'b1;
    ifc.req_ready_i = 1'b1;
    @(negedge clk);
    chk("abort_mask", ifc.req_valid_o, 1'b0);
    cyc();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_drain", busy, 1'b1);
    chk("abort_not_counted", inflight, 16'd0);
    cyc();
    @(negedge clk);
    chk("abort_idle", busy, 1'b0);
    cyc();

    // rearm, with an ack coinciding with a handshake
    send_entry(mk(58'h10, 1'b0, 1'b1, 1'b1, 16'd0, 16'd0, 32'd2, 16'd0, 16'd0));
    for (int k = 0; k < 4; k++) begin
      ack = (k == 2);
      @(negedge clk);
      chk("rearm_addr", ifc.req_addr_o, {58'h10 + 58'(2 * k), 6'b000000});
      if (k == 3) chk("hs_ack_inflight", inflight, 16'd2);
      cyc();
    end
    ack = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    chk("rearm_abort_mask", ifc.req_valid_o, 1'b0);
    cyc();
    abort = 1'b0;
    ack_n(3);
    wait_idle("rearm_idle");

    // cycle has priority over rearm: same line repeats
    send_entry(mk(58'h10, 1'b1, 1'b1, 1'b1, 16'd0, 16'd0, 32'd2, 16'd0, 16'd0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("cycle_addr", ifc.req_addr_o, 64'h400);
      cyc();
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    ack_n(3);
    wait_idle("cycle_idle");

    // disabled entry is consumed without starting
    send_entry(mk(58'h77, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 32'd1, 16'd0, 16'd0));
    @(negedge clk);
    chk("dis_busy", busy, 1'b0);
    chk("dis_valid", ifc.req_valid_o, 1'b0);
    cyc();

    // reset mid-stream
    send_entry(mk(58'h300, 1'b0, 1'b0, 1'b1, 16'd0, 16'd15, 32'd1, 16'd0, 16'd0));
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
    @(negedge clk);
    chk("mrst_valid", ifc.req_valid_o, 1'b0);
    chk("mrst_addr", ifc.req_addr_o, 64'h0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_inflight", inflight, 16'd0);
    chk("mrst_ready", ifc.entry_ready_o, 1'b0);
    cyc();
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) chk("mrst_ready_after", ifc.entry_ready_o, 1'b1);
      if (ifc.req_valid_o) cnt++;
      cyc();
    end
    chk("mrst_no_requests", cnt, 0);

    // randomized streams against the reference model
    for (int s = 0; s < 20; s++) begin
      rbase   = {$urandom, $urandom};
      rstride = $urandom;
      rnl     = $urandom_range(0, 3);
      rnb     = $urandom_range(0, 3);
      rnw     = $urandom_range(0, 2);
      ni      = $urandom_range(0, 3);
      q.delete();
      for (int b = 0; b <= rnb; b++)
        for (int l = 0; l <= rnl; l++)
          q.push_back(ref_addr(rbase, rstride, b, l));
      m_inf = 0;
      ifc.req_ready_i = 1'b1;
      send_entry(mk(rbase, 1'b0, 1'b0, 1'b1, 16'(rnb), 16'(rnl), rstride, 16'(ni), 16'(rnw)));
      budget = 0;
      while ((q.size() > 0 || m_inf > 0) && budget < 500) begin
        ifc.req_ready_i = ($urandom_range(0, 3) != 0);
        ack = (m_inf > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
        @(negedge clk);
        chk("rnd_inflight", inflight, 16'(m_inf));
        hs = ifc.req_valid_o && ifc.req_ready_i;
        if (ifc.req_valid_o && ni != 0) chk("rnd_throttle", (m_inf < ni), 1'b1);
        if (hs) begin
          if (q.size() == 0) begin
            chk("rnd_extra_req", hs, 1'b0);
          end else begin
            a0 = q.pop_front();
            chk("rnd_addr", ifc.req_addr_o, a0);
          end
        end
        m_inf = m_inf + (hs ? 1 : 0) - ((ack && m_inf > 0) ? 1 : 0);
        cyc();
        budget++;
      end
      chk("rnd_budget", q.size(), 0);
      ack = 1'b0;
      ifc.req_ready_i = 1'b1;
      wait_idle("rnd_idle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
